// File: rtl/seg_pkg.sv
// seg_pkg: shared widths, PWM constants, idle output levels and default sizing for the seven-segment scanner
package seg_pkg;
  localparam int BRIGHT_W = 4;
  localparam int PWM_PHASES = 16;
  localparam logic EN_OFF = 1'b1;
  localparam logic SEG_BLANK = 1'b0;
  localparam int DEF_NUM_DIGITS = 8;
  localparam int DEF_SCAN_DIV = 100000;
  typedef logic [BRIGHT_W-1:0] bright_t;
endpackage

// File: rtl/seg_prescaler.sv
// seg_prescaler: slot prescaler; pre counts 0..SCAN_DIV-1, phase = pre/(SCAN_DIV/16) via a sub-counter, slot_wrap marks the last cycle of a slot (ports: clk, rst, pre, phase, slot_wrap)
module seg_prescaler
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = DEF_SCAN_DIV
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [$clog2(SCAN_DIV)-1:0] pre,
  output bright_t                     phase,
  output logic                        slot_wrap
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int SUB = SCAN_DIV / PWM_PHASES;
  localparam int SW = $clog2(SUB);
  logic [SW-1:0] sub;
  assign slot_wrap = pre == PW'(SCAN_DIV - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      sub <= '0;
      phase <= '0;
    end else if (slot_wrap) begin
      pre <= '0;
      sub <= '0;
      phase <= '0;
    end else begin
      pre <= pre + 1'b1;
      sub <= sub == SW'(SUB - 1) ? '0 : sub + 1'b1;
      phase <= sub == SW'(SUB - 1) ? phase + 1'b1 : phase;
    end
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment scan driver with frame-coherent shadowing, blanking, 16-level PWM and a dead cycle per slot; optional blink via SEG_SCAN_BLINK_EN (ports: clk, rst, seg_in, blank_mask, brightness, [blink_mask], o_seg_en, seg_out, frame_start)
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int SEG_W = 8,
  parameter int SCAN_DIV = DEF_SCAN_DIV,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]       blank_mask,
  input  bright_t                     brightness,
`ifdef SEG_SCAN_BLINK_EN
  input  logic [NUM_DIGITS-1:0]       blink_mask,
`endif
  output logic [NUM_DIGITS-1:0]       o_seg_en,
  output logic [SEG_W-1:0]            seg_out,
  output logic                        frame_start
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  if (NUM_DIGITS < 1 || NUM_DIGITS > 16) $error("NUM_DIGITS out of range");
  if (SCAN_DIV % PWM_PHASES != 0 || SCAN_DIV < 32) $error("SCAN_DIV invalid");
  if (BLINK_FRAMES < 1) $error("BLINK_FRAMES invalid");
  logic [PW-1:0] pre;
  bright_t phase;
  logic slot_wrap;
  seg_prescaler #(.SCAN_DIV(SCAN_DIV)) u_pre (
    .clk(clk),
    .rst(rst),
    .pre(pre),
    .phase(phase),
    .slot_wrap(slot_wrap)
  );
  logic [IW-1:0] idx, pos;
  logic [NUM_DIGITS*SEG_W-1:0] seg_sh;
  logic [NUM_DIGITS-1:0] blank_sh, dark, en_nxt;
  bright_t bri_sh;
  logic frame_cyc, lit;
  logic [SEG_W-1:0] dig [NUM_DIGITS];
  assign frame_cyc = idx == '0 && pre == '0;
  assign pos = LAST - idx;
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    assign dig[g] = seg_sh[(NUM_DIGITS-1-g)*SEG_W +: SEG_W];
  end
`ifdef SEG_SCAN_BLINK_EN
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [FW-1:0] fcnt;
  logic blink_phase;
  logic [NUM_DIGITS-1:0] blink_sh;
  // frames are counted at frame end so frame 0 after reset is a full first frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt <= '0;
      blink_phase <= 1'b0;
      blink_sh <= '0;
    end else begin
      if (frame_cyc) blink_sh <= blink_mask;
      if (slot_wrap && idx == LAST) begin
        fcnt <= fcnt == FW'(BLINK_FRAMES - 1) ? '0 : fcnt + 1'b1;
        blink_phase <= fcnt == FW'(BLINK_FRAMES - 1) ? ~blink_phase : blink_phase;
      end
    end
  end
  assign dark = blank_sh | (blink_phase ? blink_sh : '0);
`else
  assign dark = blank_sh;
`endif
  // pre==0 is always dark so the segment bus can switch without ghosting
  assign lit = pre != '0 && phase <= bri_sh && !dark[pos];
  always_comb begin
    en_nxt = {NUM_DIGITS{EN_OFF}};
    en_nxt[pos] = lit ? ~EN_OFF : EN_OFF;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      seg_sh <= '0;
      blank_sh <= '0;
      bri_sh <= '0;
    end else begin
      if (slot_wrap) idx <= idx == LAST ? '0 : idx + 1'b1;
      if (frame_cyc) begin
        seg_sh <= seg_in;
        blank_sh <= blank_mask;
        bri_sh <= brightness;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_seg_en <= {NUM_DIGITS{EN_OFF}};
      seg_out <= {SEG_W{SEG_BLANK}};
      frame_start <= 1'b0;
    end else begin
      o_seg_en <= en_nxt;
      seg_out <= dig[idx];
      frame_start <= frame_cyc;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed self-checking bench for seg_scan_ctrl with 4 digits and a 32-cycle slot
module tb_seg_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] seg_in = 32'h11223344;
  logic [3:0] blank_mask = 4'b0000;
  logic [3:0] brightness = 4'd15;
`ifdef SEG_SCAN_BLINK_EN
  logic [3:0] blink_mask = 4'b0000;
`endif
  logic [3:0] o_seg_en;
  logic [7:0] seg_out;
  logic frame_start;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  seg_scan_ctrl #(.NUM_DIGITS(4), .SEG_W(8), .SCAN_DIV(32), .BLINK_FRAMES(2)) dut (
    .clk(clk),
    .rst(rst),
    .seg_in(seg_in),
    .blank_mask(blank_mask),
    .brightness(brightness),
`ifdef SEG_SCAN_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .o_seg_en(o_seg_en),
    .seg_out(seg_out),
    .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic run_to(input int k);
    while (cyc < k) step();
  endtask
  // cycle after whose posedge the outputs show frame f, digit d, pre p
  function automatic int kk(input int f, input int d, input int p);
    return 128 * f + 32 * d + p + 1;
  endfunction
  logic [3:0] en_exp [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  logic [7:0] seg_exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic blink_on;
  initial begin
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_en", o_seg_en, 4'hF);
      chk("rst_seg", seg_out, 8'h00);
      chk("rst_fs", frame_start, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    run_to(kk(0, 0, 0));
    chk("fs_first", frame_start, 1'b1);
    for (int d = 0; d < 4; d++) begin
      run_to(kk(0, d, 0));
      chk("dead_en", o_seg_en, 4'hF);
      run_to(kk(0, d, 1));
      chk("scan_en", o_seg_en, en_exp[d]);
      chk("scan_seg", seg_out, seg_exp[d]);
      if (d == 0) chk("fs_low", frame_start, 1'b0);
      run_to(kk(0, d, 31));
      chk("scan_last", o_seg_en, en_exp[d]);
    end
    chk("fs_end", frame_start, 1'b0);
    brightness = 4'd0;
    run_to(kk(1, 0, 0));
    chk("fs_128", frame_start, 1'b1);
    run_to(kk(1, 0, 1));
    chk("pwm0_lit", o_seg_en, 4'b0111);
    run_to(kk(1, 0, 2));
    chk("pwm0_dark", o_seg_en, 4'hF);
    brightness = 4'd7;
    run_to(kk(2, 0, 0));
    chk("fs_256", frame_start, 1'b1);
    run_to(kk(2, 0, 15));
    chk("pwm7_lit", o_seg_en, 4'b0111);
    run_to(kk(2, 0, 16));
    chk("pwm7_dark", o_seg_en, 4'hF);
    brightness = 4'd15;
    blank_mask = 4'b0100;
    run_to(kk(3, 0, 1));
    chk("blank_d0", o_seg_en, 4'b0111);
    run_to(kk(3, 1, 1));
    chk("blank_d1", o_seg_en, 4'hF);
    chk("blank_seg", seg_out, 8'h22);
    run_to(kk(3, 2, 1));
    chk("blank_d2", o_seg_en, 4'b1101);
    seg_in = 32'hAABBCCDD;
    blank_mask = 4'b0000;
    run_to(kk(3, 2, 2));
    chk("shadow_d2", seg_out, 8'h33);
    run_to(kk(3, 3, 1));
    chk("shadow_d3_en", o_seg_en, 4'b1110);
    chk("shadow_d3", seg_out, 8'h44);
    run_to(kk(4, 0, 1));
    chk("new_d0_en", o_seg_en, 4'b0111);
    chk("new_d0", seg_out, 8'hAA);
    run_to(kk(4, 1, 1));
    chk("new_d1_en", o_seg_en, 4'b1011);
    chk("new_d1", seg_out, 8'hBB);
    run_to(kk(4, 1, 5));
    rst = 1'b1;
    #1;
    chk("mid_rst_en", o_seg_en, 4'hF);
    chk("mid_rst_seg", seg_out, 8'h00);
    chk("mid_rst_fs", frame_start, 1'b0);
    @(negedge clk);
    @(negedge clk);
`ifdef SEG_SCAN_BLINK_EN
    blink_mask = 4'b1000;
`endif
    rst = 1'b0;
    cyc = 0;
    run_to(kk(0, 0, 0));
    chk("restart_fs", frame_start, 1'b1);
    chk("restart_en", o_seg_en, 4'hF);
    for (int f = 0; f < 6; f++) begin
`ifdef SEG_SCAN_BLINK_EN
      blink_on = f == 2 || f == 3;
`else
      blink_on = 1'b0;
`endif
      run_to(kk(f, 0, 1));
      chk("blink_d0_en", o_seg_en, blink_on ? 4'hF : 4'b0111);
      chk("blink_d0_seg", seg_out, 8'hAA);
      run_to(kk(f, 1, 1));
      chk("blink_d1_en", o_seg_en, 4'b1011);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Parametrised time-multiplexed seven-segment scan driver, successor to the fixed 8-digit scanner. Runs entirely on the system clock using an enable tick, with no derived clocks. Adds frame-coherent input shadowing, per-digit blanking, 16-level PWM brightness and an anti-ghosting dead cycle. Sits between the Morse decoder's character-to-segment encoder and the board's digit and segment pins.

Parameters:
NUM_DIGITS, 8, number of multiplexed digits (1..16)
SEG_W, 8, segment bits per digit (7 segments + dp)
SCAN_DIV, 100000, clk cycles per digit slot; must be a multiple of 16 and >= 32
BLINK_FRAMES, 64, frames per blink half-period (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
seg_in  in  NUM_DIGITS*SEG_W  segment patterns; top slice = leftmost digit (digit 0)
blank_mask  in  NUM_DIGITS  1 = digit forced dark; bit positions match o_seg_en
brightness  in  4  duty level 0..15
o_seg_en  out  NUM_DIGITS  digit enables, active-low; MSB = digit 0
seg_out  out  SEG_W  segment pattern for the active digit, passed through unmodified
frame_start  out  1  one-cycle pulse at the start of each frame

Behaviour:
- Reset (async): pre=0, idx=0, shadow regs=0, o_seg_en=all 1, seg_out=0, frame_start=0. While rst is high, all outputs hold these values.
- pre counts 0..SCAN_DIV-1 and wraps. On wrap, idx advances 0..NUM_DIGITS-1 and wraps to 0. With NUM_DIGITS=1, idx stays 0 and every slot is a frame.
- Frame-start cycle is any cycle with idx==0 and pre==0. In that cycle, seg_in, blank_mask and brightness load into shadow registers. Mid-frame changes to these inputs are ignored until the next frame.
- Outputs are registered, one cycle after (idx, pre, shadow):
  - seg_out = shadow slice [idx].
  - o_seg_en bit (NUM_DIGITS-1-idx) = 0 only when pre!=0, AND phase<=brightness_shadow, AND blank_shadow for that bit is 0. All other enable bits are 1.
  - phase = pre/(SCAN_DIV/16), 0..15, implemented with a sub-counter (no divider).
  - frame_start = 1 in the cycle after the frame-start cycle.
- pre==0 is a dead cycle: all enables off while seg_out changes (anti-ghosting).
- Latency: seg_in captured at frame-start cycle T. Digit 0 is first lit at T+2.
- Frame period = NUM_DIGITS*SCAN_DIV cycles.
- Lit cycles per slot = (brightness+1)*SCAN_DIV/16 - 1. Brightness 15 = SCAN_DIV-1 cycles.
- Reset asserted mid-slot: outputs go off immediately. After release, the scan restarts at digit 0 with a fresh frame start.
- Counter widths: $clog2(SCAN_DIV) and $clog2(NUM_DIGITS), minimum 1. No wrap-around beyond the terminal count.

Optional Feature:
SEG_SCAN_BLINK_EN
- Defined:
  - Adds input port blink_mask [NUM_DIGITS], shadowed at frame start.
  - Frame counter toggles blink_phase every BLINK_FRAMES frames; blink_phase resets to 0.
  - When blink_phase=1, digits whose blink_mask bit is set are dark, exactly as if blanked.
- Undefined: port, frame counter and blink_phase are absent; behaviour is identical to defined with blink_mask=0.

Decomposition:
- Package seg_pkg holds:
  - BRIGHT_W=4 and PWM_PHASES=16
  - EN_OFF and SEG_BLANK constants
  - default NUM_DIGITS and SCAN_DIV
- Sub-module seg_prescaler, parameterised by SCAN_DIV, owns pre and the phase sub-counter and emits slot_wrap and phase.
- Digit sequencing, shadowing and output registers stay in seg_scan_ctrl.

Test Plan:
Bench config for all scenarios: NUM_DIGITS=4, SEG_W=8, SCAN_DIV=32.
1. Reset: hold rst for 5 cycles -> o_seg_en=4'hF, seg_out=8'h00, frame_start=0 throughout.
2. Normal scan: seg_in=32'h11223344, brightness=15, blank_mask=0 -> each slot has 1 cycle 4'hF followed by 31 cycles lit. Sequence is 4'b0111/8'h11, 4'b1011/8'h22, 4'b1101/8'h33, 4'b1110/8'h44. frame_start pulses every 128 cycles.
3. PWM: brightness=0 -> 1 lit cycle per slot; brightness=7 -> 15 lit cycles (pre 1..15), then dark for pre 16..31.
4. Shadowing: change seg_in to 32'hAABBCCDD during digit 2 -> digits 2 and 3 still show 8'h33/8'h44. New values appear from the next frame_start+1.
5. Blanking: blank_mask=4'b0100 -> the 8'h22 slot keeps o_seg_en=4'hF; other digits are unaffected.
6. Mid-slot reset, plus blink with SEG_SCAN_BLINK_EN and BLINK_FRAMES=2:
   - rst pulsed during digit 1 -> same-cycle 4'hF; restart at digit 0.
   - blink_mask=4'b1000 -> digit 0 dark in frames 2-3, lit in frames 0-1 and 4-5.
